// File: rtl/monolith_pkg.sv
// Shared constants, field/state types and FSM encoding for the Monolith concrete layer.
package monolith_pkg;

  localparam int WORD_WIDTH = 31;
  localparam int STATE_SIZE = 16;
  localparam logic [WORD_WIDTH-1:0] MERSENNE_P = '1;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [STATE_SIZE-1:0] state_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    REDUCE,
    DONE
  } concrete_state_e;

endpackage

// File: rtl/mersenne_reduce.sv
// Combinational reduction of an arbitrary-width value modulo 2^W - 1 to a canonical word.
module mersenne_reduce
  import monolith_pkg::*;
#(
  parameter int W    = monolith_pkg::WORD_WIDTH,
  parameter int IN_W = 2 * monolith_pkg::WORD_WIDTH + 4
) (
  input  logic [IN_W-1:0] a_i,
  output logic [W-1:0]    r_o
);

  // Working width must hold p + 1 so the final folds cannot overflow.
  localparam int FW    = (IN_W > W + 1) ? IN_W : W + 1;
  localparam int FOLDS = (IN_W + W - 1) / W + 2;
  localparam logic [FW-1:0] P_EXT = {{(FW - W){1'b0}}, {W{1'b1}}};

  logic [FW-1:0] stage [FOLDS+1];
  logic [FW-1:0] fin;

  assign stage[0] = FW'(a_i);

  for (genvar gi = 0; gi < FOLDS; gi++) begin : g_fold
    assign stage[gi+1] = (stage[gi] & P_EXT) + (stage[gi] >> W);
  end

  assign fin = stage[FOLDS];
  assign r_o = (fin >= P_EXT) ? W'(fin - P_EXT) : W'(fin);

endmodule

// File: rtl/monolith_concrete_seq.sv
// Time-multiplexed circulant MDS layer: state_out = C * state_in (+ rc) mod 2^W - 1,
// computing LANES output words per group of N+1 cycles.
module monolith_concrete_seq
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = monolith_pkg::WORD_WIDTH,
  parameter int STATE_SIZE = monolith_pkg::STATE_SIZE,
  parameter int LANES      = 4,
  parameter int ADD_RC     = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  state_in,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  rc_in,
  input  logic                                   mtx_we,
  input  logic [$clog2(STATE_SIZE)-1:0]          mtx_addr,
  input  logic [WORD_WIDTH-1:0]                  mtx_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  state_out,
  output logic                                   busy
);

  localparam int N      = STATE_SIZE;
  localparam int AW     = $clog2(N);
  localparam int IW     = AW + 1;
  localparam int PW     = 2 * WORD_WIDTH;
  localparam int ACC_W  = 2 * WORD_WIDTH + AW;
  localparam int GROUPS = N / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (N < 2) begin : g_bad_size
    $error("STATE_SIZE must be at least 2");
  end
  if (N % LANES != 0) begin : g_bad_lanes
    $error("LANES must divide STATE_SIZE");
  end

  typedef logic [WORD_WIDTH-1:0] lword_t;

  concrete_state_e state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [AW-1:0]   t_q, t_d;

  lword_t                                row_q [N];
  logic [N-1:0][WORD_WIDTH-1:0]          x_q;
  logic [N-1:0][WORD_WIDTH-1:0]          rc_q;
  logic [N-1:0][WORD_WIDTH-1:0]          out_q;

  lword_t          lane_res [LANES];
  logic [IW-1:0]   lane_idx [LANES];

  logic accept;
  logic mtx_wr_en;

  assign accept    = (state_q == IDLE) && in_valid;
  // The row is frozen while a vector is in flight.
  assign mtx_wr_en = mtx_we && ((state_q == IDLE) || (state_q == DONE))
                     && ({1'b0, mtx_addr} < IW'(N));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == REDUCE);
  assign state_out = out_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          g_d     = '0;
          t_d     = '0;
        end
      end
      CALC: begin
        if (t_q == AW'(N - 1)) begin
          t_d     = '0;
          state_d = REDUCE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      REDUCE: begin
        if (g_q == GW'(GROUPS - 1)) begin
          state_d = DONE;
        end else begin
          g_d     = g_q + 1'b1;
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      t_q     <= t_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q   <= '0;
      rc_q  <= '0;
      out_q <= '0;
      for (int r = 0; r < N; r++) row_q[r] <= '0;
    end else begin
      if (mtx_wr_en) row_q[mtx_addr] <= mtx_data;
      if (accept) begin
        x_q  <= state_in;
        rc_q <= rc_in;
      end
      if (state_q == REDUCE) begin
        for (int k = 0; k < LANES; k++) out_q[lane_idx[k][AW-1:0]] <= lane_res[k];
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IW-1:0]       row_sum, row_idx;
    logic [PW-1:0]       prod;
    lword_t              red, rc_word;
    logic [WORD_WIDTH:0] rc_sum;

    assign lane_idx[gi] = IW'(g_q) * IW'(LANES) + IW'(gi);
    // Circulant coefficient index (j - i) mod N, kept non-negative by adding N.
    assign row_sum = IW'(t_q) + IW'(N) - lane_idx[gi];
    assign row_idx = (row_sum >= IW'(N)) ? row_sum - IW'(N) : row_sum;
    assign prod    = PW'(row_q[row_idx[AW-1:0]]) * PW'(x_q[t_q]);

    always_comb begin
      acc_d = acc_q;
      if (accept || (state_q == REDUCE)) begin
        acc_d = '0;
      end else if (state_q == CALC) begin
        acc_d = acc_q + ACC_W'(prod);
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) acc_q <= '0;
      else        acc_q <= acc_d;
    end

    mersenne_reduce #(.W(WORD_WIDTH), .IN_W(ACC_W)) u_fold (
      .a_i (acc_q),
      .r_o (red)
    );

    assign rc_word = (ADD_RC != 0) ? rc_q[lane_idx[gi][AW-1:0]] : '0;
    assign rc_sum  = {1'b0, red} + {1'b0, rc_word};

    mersenne_reduce #(.W(WORD_WIDTH), .IN_W(WORD_WIDTH + 1)) u_rc (
      .a_i (rc_sum),
      .r_o (lane_res[gi])
    );
  end

endmodule

// File: tb/tb_monolith_concrete_seq.sv
// Scoreboard bench for monolith_concrete_seq: directed and random vectors against a modular-arithmetic model.
module tb_monolith_concrete_seq;
  import monolith_pkg::*;

  localparam int N   = STATE_SIZE;
  localparam int W   = WORD_WIDTH;
  localparam int AW  = $clog2(N);
  localparam int LAT = (N / 4) * (N + 1);
  localparam longint unsigned P = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, mtx_we, out_valid, out_ready, busy;
  state_vec_t state_in, rc_in, state_out;
  logic [AW-1:0] mtx_addr;
  word_t mtx_data;

  monolith_concrete_seq #(.WORD_WIDTH(W), .STATE_SIZE(N), .LANES(4), .ADD_RC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .rc_in     (rc_in),
    .mtx_we    (mtx_we),
    .mtx_addr  (mtx_addr),
    .mtx_data  (mtx_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  word_t      row_m [N];
  state_vec_t sb_q [$];
  int         lat_q [$];
  state_vec_t last_exp;
  bit         prev_ov = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); edges++; end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, longint unsigned got, longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(string name, state_vec_t got, state_vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      for (int i = 0; i < N; i++) begin
        if (got[i] !== exp[i]) begin
          $display("FAIL %s word %0d got %0d expected %0d", name, i, got[i], exp[i]);
          break;
        end
      end
    end
  endtask

  // result[i] = sum_j row[(j-i) mod N] * x[j] + rc[i], all mod p
  function automatic state_vec_t model(state_vec_t x, state_vec_t rc);
    state_vec_t res;
    longint unsigned acc;
    for (int i = 0; i < N; i++) begin
      acc = 0;
      for (int j = 0; j < N; j++) begin
        acc = (acc + (longint'(row_m[(j - i + N) % N]) * longint'(x[j])) % P) % P;
      end
      acc = (acc + longint'(rc[i])) % P;
      res[i] = word_t'(acc);
    end
    return res;
  endfunction

  function automatic word_t rand_word();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return word_t'(P);
    if (sel == 1) return word_t'(P - 1);
    return word_t'($urandom);
  endfunction

  initial begin
    state_vec_t exp;
    int a;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          exp = sb_q.pop_front();
          a   = lat_q.pop_front();
          chk_vec("result", state_out, exp);
          chk("latency", edges - a, LAT);
          last_exp = exp;
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue_w(state_vec_t x, state_vec_t rc, bit we, int addr, word_t data);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; state_in = x; rc_in = rc;
    mtx_we = we; mtx_addr = addr[AW-1:0]; mtx_data = data;
    if (we) row_m[addr] = data;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", in_ready, 1);
    else begin
      sb_q.push_back(model(x, rc));
      lat_q.push_back(edges + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mtx_we = 1'b0;
  endtask

  task automatic issue(state_vec_t x, state_vec_t rc);
    issue_w(x, rc, 1'b0, 0, '0);
  endtask

  task automatic mtx_write(int addr, word_t data, bit apply);
    @(posedge clk); #1;
    mtx_we = 1'b1; mtx_addr = addr[AW-1:0]; mtx_data = data;
    @(posedge clk); #1;
    mtx_we = 1'b0;
    if (apply) row_m[addr] = data;
  endtask

  task automatic load_identity();
    mtx_write(0, 31'd1, 1'b1);
    for (int r = 1; r < N; r++) mtx_write(r, '0, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout got pending %0d expected 0", sb_q.size());
    end
  endtask

  initial begin
    state_vec_t x, rc, zero;
    bit ok;
    zero = '0;
    reset = 1'b0; in_valid = 1'b0; mtx_we = 1'b0; mtx_addr = '0; mtx_data = '0;
    out_ready = 1'b1; state_in = '0; rc_in = '0;
    for (int r = 0; r < N; r++) row_m[r] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_vec("rst_state_out", state_out, zero);

    // identity and shift orientation
    mtx_write(0, 31'd1, 1'b1);
    for (int j = 0; j < N; j++) x[j] = word_t'(j);
    issue(x, zero); wait_idle();
    mtx_write(0, '0, 1'b1);
    mtx_write(1, 31'd1, 1'b1);
    issue(x, zero); wait_idle();

    // modular wrap: 16 * 2 * (p-1) = p-32
    for (int r = 0; r < N; r++) mtx_write(r, 31'd2, 1'b1);
    for (int j = 0; j < N; j++) x[j] = word_t'(P - 1);
    issue(x, zero); wait_idle();

    // round constants and inputs equal to p
    load_identity();
    for (int j = 0; j < N; j++) rc[j] = 31'd1;
    issue(x, rc); wait_idle();
    for (int j = 0; j < N; j++) begin x[j] = word_t'(P); rc[j] = 31'd3; end
    issue(x, rc); wait_idle();
    mtx_write(0, '0, 1'b1);
    for (int j = 0; j < N; j++) begin x[j] = rand_word(); rc[j] = 31'd5; end
    issue(x, rc); wait_idle();

    // write and accept in the same cycle: new word must be used
    for (int j = 0; j < N; j++) x[j] = word_t'(j);
    issue_w(x, zero, 1'b1, 0, 31'd9); wait_idle();

    // randomized rows and vectors
    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < N; r++) mtx_write(r, rand_word(), 1'b1);
      for (int j = 0; j < N; j++) begin x[j] = rand_word(); rc[j] = rand_word(); end
      issue(x, rc); wait_idle();
    end

    // backpressure: output held, no new input accepted
    out_ready = 1'b0;
    for (int j = 0; j < N; j++) begin x[j] = rand_word(); rc[j] = rand_word(); end
    issue(x, rc);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("bp_out_valid_seen", out_valid, 1);
    if (ok) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk_vec("hold_data", state_out, last_exp);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // matrix write during CALC must be ignored
    for (int j = 0; j < N; j++) begin x[j] = rand_word(); rc[j] = rand_word(); end
    issue(x, rc);
    repeat (5) @(posedge clk);
    mtx_write(0, 31'd12345, 1'b0);
    wait_idle();
    for (int j = 0; j < N; j++) x[j] = rand_word();
    issue(x, zero); wait_idle();

    // reset in the middle of CALC
    for (int j = 0; j < N; j++) x[j] = rand_word();
    issue(x, zero);
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    sb_q.delete(); lat_q.delete();
    for (int r = 0; r < N; r++) row_m[r] = '0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk_vec("mid_rst_state_out", state_out, zero);
    for (int j = 0; j < N; j++) x[j] = rand_word();
    issue(x, zero); wait_idle();
    load_identity();
    for (int j = 0; j < N; j++) x[j] = word_t'(j);
    issue(x, zero); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/monolith_concrete_seq.md
Name: monolith_concrete_seq

Overview:
Parametrised, time-multiplexed successor to the fixed Monolith concrete layer. Computes state_out = C * state_in + rc (mod p = 2^WORD_WIDTH - 1), where C is a circulant MDS matrix given by its first row.
- The first row is runtime-loadable instead of a fixed constant.
- Round-constant addition is optional.
- Valid/ready handshakes on both input and output.
- Computes LANES output words in parallel, trading area for latency.
- Sits between the bricks and bars layers of the Monolith permutation.

Parameters:
- WORD_WIDTH, 31, field element width; modulus p = 2^WORD_WIDTH - 1 (M31 by default).
- STATE_SIZE, 16, number of state words N.
- LANES, 4, multiply-accumulate units (outputs computed in parallel); must divide STATE_SIZE, else elaboration error.
- ADD_RC, 1, 1 = add rc_in after the product; 0 = rc_in ignored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  state_in/rc_in valid.
- in_ready  out  1  block accepts input.
- state_in  in  WORD_WIDTH x STATE_SIZE  input state.
- rc_in  in  WORD_WIDTH x STATE_SIZE  round constants, captured with state_in.
- mtx_we  in  1  write one matrix first-row word.
- mtx_addr  in  clog2(STATE_SIZE)  row index to write.
- mtx_data  in  WORD_WIDTH  row word value.
- out_valid  out  1  state_out valid.
- out_ready  in  1  downstream accepts output.
- state_out  out  WORD_WIDTH x STATE_SIZE  result, canonical in [0, p-1].
- busy  out  1  high in CALC or REDUCE.

Behaviour:
- Arithmetic:
  - result[i] = sum over j of row[(j - i) mod N] * x[j] (+ rc[i]) mod p.
  - Inputs equal to p (all ones) are treated as 0.
  - Accumulator width is 2*WORD_WIDTH + clog2(N); no intermediate reduction.
  - Final reduction is a Mersenne fold: (a & p) + (a >> WORD_WIDTH), repeated until the value fits, then conditional subtraction of p.
  - A result equal to p is output as 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, capture state_in and rc_in, clear group and term counters and accumulators, go to CALC.
  - CALC: each cycle, lane k accumulates row[(j - i) mod N] * x[j] for i = g*LANES + k, j = term counter. After term N-1, go to REDUCE.
  - REDUCE: one cycle. Reduce each lane, add rc (if ADD_RC) with modular correction, write to output register slot i, clear accumulators. If g < N/LANES - 1: increment g, go to CALC. Otherwise go to DONE.
  - DONE: out_valid = 1, state_out stable. When out_ready = 1, go to IDLE.
- Latency: out_valid rises exactly (N/LANES)*(N+1) clock edges after the accepting edge; 68 with defaults.
- Throughput: one vector per latency + 2 cycles. No overlap; in_ready = 0 outside IDLE.
- out_valid stays high with state_out held until out_ready = 1; out_ready has no effect when out_valid = 0.
- Matrix load: mtx_we is honoured only in IDLE or DONE and writes row[mtx_addr] at the clock edge. It is ignored while busy = 1, so the matrix is stable for the whole computation.
- mtx_we and in_valid in the same IDLE cycle: the write happens first and the captured computation uses the new word.
- Reset (reset = 0 at a clock edge), including mid-operation:
  - FSM returns to IDLE; counters, accumulators and captured data are cleared.
  - Matrix row is cleared to zero.
  - out_valid = 0, busy = 0, in_ready = 1 after reset; state_out all zero.
- state_out is registered and changes only in REDUCE or on reset.

Decomposition:
- Package monolith_pkg holds:
  - WORD_WIDTH and STATE_SIZE defaults, and the MERSENNE_P constant.
  - A field-word typedef and a state-vector typedef.
  - The FSM state enum concrete_state_e (IDLE, CALC, REDUCE, DONE).
- Sub-module mersenne_reduce: combinational wide-to-WORD_WIDTH fold plus canonicalisation, instantiated LANES times. The same block also serves the rc addition with a narrow input.

Test Plan:
- Identity: write row = [1,0,...,0], state[j] = j, rc = 0, ADD_RC = 1 → state_out[i] = i. out_valid rises exactly 68 edges after acceptance.
- Shift: row[1] = 1, all other row words 0, state[j] = j → state_out[i] = (i+1) mod 16. Confirms the circulant orientation.
- Modular wrap: row words all 2, state words all p-1 = 2147483646, rc = 0 → every output = p-32 = 2147483615.
- Round constants: identity row, state words all p-1, rc words all 1 → all outputs 0. With a zero row and rc = 5 → all outputs 5. state_in = 0x7FFFFFFF (equal to p) behaves as 0.
- Backpressure and matrix protection: hold out_ready = 0 for 10 cycles after out_valid → out_valid and data held, in_ready = 0. An mtx_we pulse during CALC leaves the matrix unchanged; verify by recomputing.
- Reset mid-operation: assert reset = 0 at cycle 20 of CALC → next cycle out_valid = 0, busy = 0, in_ready = 1, state_out zero, matrix zero. A new identity computation after reloading the row is correct.
